aes_block_collector: RTL and testbench
======================================

// Module: aes_block_collector
// PURPOSE
//  Downstream of the byte-serial AES core. Consumes the core's output stream
//  (output_valid / out_byte_num / data_out) and reassembles 16 bytes into one 128-bit block.
//  Buffers completed blocks in a small FIFO and offers them on a valid/ready block port.
//  Detects byte-order errors and FIFO overflow.
// PARAMETERS
//  DEPTH    2    completed-block FIFO entries; power of 2, >= 2
//  CNT_W    16   width of delivered-block counter
// PORTS
//  clk          in   1     single clock; all logic on posedge clk
//  rst          in   1     synchronous, active-low reset (0 = reset)
//  in_valid     in   1     byte strobe; from AES output_valid
//  in_byte_num  in   4     byte index 0..15; from AES out_byte_num
//  in_data      in   8     byte value; from AES data_out
//  blk_valid    out  1     head FIFO entry is available
//  blk_ready    in   1     consumer accepts head entry when blk_valid & blk_ready
//  blk_data     out  128   head block; byte n at [127-8n -: 8] (byte 0 = MSB)
//  blk_count    out  CNT_W blocks delivered (handshakes), wraps modulo 2^CNT_W
//  seq_err      out  1     sticky: byte-order violation seen
//  overflow     out  1     sticky: completed block dropped, FIFO full
//  clear_err    in   1     clears seq_err and overflow next edge
// BEHAVIOUR
//  - Reset (rst=0 at posedge): FSM->WAIT0, byte counter=0, assembly reg=0, FIFO empty;
//    blk_valid=0, blk_data=0, blk_count=0, seq_err=0, overflow=0. Reset aborts any partial block.
//  - FSM states:
//    WAIT0:   expects byte 0.
//    COLLECT: expects byte exp (1..15).
//    RESYNC:  discards bytes until byte 0.
//  - WAIT0: in_valid & num==0 -> store byte 0, exp=1, go COLLECT.
//    in_valid & num!=0 -> seq_err=1, go RESYNC.
//  - COLLECT: in_valid & num==exp -> store at [127-8*num -: 8], exp++.
//    After exp==15 is accepted, the block is complete: push it to the FIFO, go WAIT0.
//  - COLLECT: in_valid & num!=exp -> discard partial, seq_err=1.
//    If num==0: store it as byte 0 of a new block, exp=1, stay COLLECT; else go RESYNC.
//  - RESYNC: in_valid & num==0 -> store byte 0, exp=1, go COLLECT; all other bytes are ignored.
//  - in_valid=0 cycles (gaps) mid-block are legal; partial block and exp are held.
//  - Latency: the byte-15 sample edge writes the FIFO; with the FIFO empty, blk_valid=1 in the
//    following cycle, with blk_data complete. No combinational path from in_* to blk_*.
//  - FIFO full at push without a pop in the same cycle -> block dropped, overflow=1, FIFO unchanged.
//    Full with a same-cycle pop -> push accepted.
//  - Pop on blk_valid & blk_ready; blk_count++ per pop, wraps 2^CNT_W-1 -> 0.
//    blk_data is stable while blk_valid & ~blk_ready.
//  - clear_err with a simultaneous new error: the error wins (flag stays 1).
//  - blk_data is don't-care when blk_valid=0; it drives 0 after reset.
// STRUCTURE
//  - aes_pkg (shared): AES_BLOCK_W=128, AES_BYTES=16, typedef logic [3:0] aes_byte_idx_t,
//    typedef logic [127:0] aes_block_t.
//  - Sub-module aes_blk_fifo: DEPTH x aes_block_t synchronous FIFO (wr/rd pointers with an
//    extra wrap bit, full/empty, registered head). Collector FSM + assembly register live in
//    this top module.
// TESTING
//  1 Bytes 0..15 on consecutive cycles, value 8'h00..8'h0F, blk_ready=1
//    -> blk_valid 1 cycle after byte 15; blk_data=128'h000102..0F; blk_count=1.
//  2 Same stream with in_valid low for 3 cycles after byte 7
//    -> identical blk_data, seq_err=0.
//  3 Bytes 0..5, then byte 9
//    -> seq_err=1, nothing pushed; then full 0..15 of 8'hAA -> block of all AA delivered.
//  4 blk_ready=0, send 3 blocks (DEPTH=2)
//    -> first two retained in order, overflow=1 on third; clear_err -> overflow=0.
//  5 FIFO full, byte 15 arrives in the same cycle as blk_ready=1
//    -> pop and push both succeed, overflow=0.
//  6 Reset (rst=0) after byte 8
//    -> all outputs 0; next full 16-byte stream delivers one correct block, no seq_err.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types used by the block collector and its FIFO.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  typedef logic [3:0]             aes_byte_idx_t;
  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    ST_WAIT0,
    ST_COLLECT,
    ST_RESYNC
  } col_state_t;

  // Byte 0 is the MSB of the block.
  function automatic aes_block_t put_byte(aes_block_t blk, aes_byte_idx_t idx, logic [7:0] d);
    aes_block_t r;
    r = blk;
    r[AES_BLOCK_W-1-8*int'(idx) -: 8] = d;
    return r;
  endfunction
endpackage

// File: rtl/aes_block_collector_if.sv
// Byte-in stream plus valid/ready block-out port of the collector.
interface aes_block_collector_if;
  import aes_pkg::*;

  logic          in_valid;
  aes_byte_idx_t in_byte_num;
  logic [7:0]    in_data;
  logic          blk_valid;
  logic          blk_ready;
  aes_block_t    blk_data;

  modport master (
    output in_valid, in_byte_num, in_data, blk_ready,
    input  blk_valid, blk_data
  );

  modport slave (
    input  in_valid, in_byte_num, in_data, blk_ready,
    output blk_valid, blk_data
  );
endinterface

// File: rtl/aes_blk_fifo.sv
// DEPTH-entry synchronous FIFO of 128-bit blocks; head is read straight from storage registers.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  aes_block_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output aes_block_t head
);
  localparam int AW = $clog2(DEPTH);

  aes_block_t  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop frees the head slot this cycle, so a push into a full FIFO may land there.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/aes_block_collector.sv
// Reassembles the AES core's byte stream into 128-bit blocks, buffers them and flags order/overflow errors.
module aes_block_collector
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_block_collector_if.slave  bus,
  input  logic                  clear_err,
  output logic [CNT_W-1:0]      blk_count,
  output logic                  seq_err,
  output logic                  overflow
);
  col_state_t    state;
  aes_byte_idx_t exp_idx;
  aes_block_t    asm_blk;

  logic       hit_exp, push, pop, full, empty, order_err, ovf_evt;
  aes_block_t push_data, head;

  assign hit_exp   = bus.in_valid && (state == ST_COLLECT) && (bus.in_byte_num == exp_idx);
  // Byte 15 is merged on the fly so the FIFO is written on the edge that samples it.
  assign push      = hit_exp && (exp_idx == 4'hF);
  assign push_data = put_byte(asm_blk, 4'hF, bus.in_data);
  assign pop       = ~empty & bus.blk_ready;
  assign order_err = bus.in_valid &&
                     (((state == ST_WAIT0)   && (bus.in_byte_num != 4'd0)) ||
                      ((state == ST_COLLECT) && (bus.in_byte_num != exp_idx)));
  assign ovf_evt   = push & full & ~pop;

  assign bus.blk_valid = ~empty;
  assign bus.blk_data  = head;

  aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_WAIT0;
      exp_idx   <= '0;
      asm_blk   <= '0;
      blk_count <= '0;
      seq_err   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (pop) blk_count <= blk_count + 1'b1;
      // A new error in the same cycle as clear_err keeps the flag set.
      seq_err  <= order_err | (seq_err  & ~clear_err);
      overflow <= ovf_evt   | (overflow & ~clear_err);

      if (bus.in_valid) begin
        case (state)
          ST_WAIT0, ST_RESYNC: begin
            if (bus.in_byte_num == 4'd0) begin
              asm_blk <= put_byte('0, 4'd0, bus.in_data);
              exp_idx <= 4'd1;
              state   <= ST_COLLECT;
            end else if (state == ST_WAIT0) begin
              state <= ST_RESYNC;
            end
          end
          ST_COLLECT: begin
            if (hit_exp) begin
              asm_blk <= put_byte(asm_blk, bus.in_byte_num, bus.in_data);
              if (exp_idx == 4'hF) begin
                exp_idx <= '0;
                state   <= ST_WAIT0;
              end else begin
                exp_idx <= exp_idx + 4'd1;
              end
            end else if (bus.in_byte_num == 4'd0) begin
              asm_blk <= put_byte('0, 4'd0, bus.in_data);
              exp_idx <= 4'd1;
            end else begin
              exp_idx <= '0;
              state   <= ST_RESYNC;
            end
          end
          default: begin
            exp_idx <= '0;
            state   <= ST_WAIT0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_block_collector.sv
// Scoreboard bench for aes_block_collector: byte-level reference model feeds an expected-block queue.
module tb_aes_block_collector;
  import aes_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear_err = 1'b0;
  logic [CNT_W-1:0] blk_count;
  logic             seq_err, overflow;

  aes_block_collector_if bus();

  aes_block_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .clear_err (clear_err),
    .blk_count (blk_count),
    .seq_err   (seq_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [127:0]     sb_q[$];
  bit               pop_pending = 0;
  bit               started = 0;
  logic             m_seq = 0, m_ovf = 0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [7:0]       m_buf[16];
  int               m_exp = 0;
  bit               m_resync = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk_blk(logic [7:0] base, bit inc);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[127-8*i -: 8] = inc ? base + 8'(i) : base;
    return b;
  endfunction

  // Model: applies the byte-ordering rules and the FIFO capacity at each sampling edge.
  always @(posedge clk) begin
    bit           err, done, ovf_new;
    int           n;
    logic [127:0] blk;
    if (!rst) begin
      sb_q.delete();
      m_exp = 0; m_resync = 0; m_seq = 0; m_ovf = 0; m_cnt = '0;
    end else begin
      err = 0; done = 0; ovf_new = 0;
      if (pop_pending) m_cnt = m_cnt + 1'b1;
      if (bus.in_valid) begin
        n = int'(bus.in_byte_num);
        if (m_exp == 0) begin
          if (n == 0) begin
            m_buf[0] = bus.in_data; m_exp = 1; m_resync = 0;
          end else if (!m_resync) begin
            err = 1; m_resync = 1;
          end
        end else if (n == m_exp) begin
          m_buf[n] = bus.in_data;
          m_exp++;
          if (m_exp == 16) begin done = 1; m_exp = 0; end
        end else begin
          err = 1;
          if (n == 0) begin m_buf[0] = bus.in_data; m_exp = 1; end
          else begin m_exp = 0; m_resync = 1; end
        end
      end
      if (done) begin
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = m_buf[i];
        if ((sb_q.size() + int'(pop_pending)) >= DEPTH && !pop_pending) ovf_new = 1;
        else sb_q.push_back(blk);
      end
      m_seq = err     | (m_seq & !clear_err);
      m_ovf = ovf_new | (m_ovf & !clear_err);
    end
    pop_pending = 0;
  end

  // Monitor: compares the block port and flags against the model on the falling edge.
  always @(negedge clk) begin
    if (started && rst) begin
      chk("blk_valid", 128'(bus.blk_valid), 128'(sb_q.size() != 0));
      if (bus.blk_valid && sb_q.size() != 0) chk("blk_data", bus.blk_data, sb_q[0]);
      chk("seq_err", 128'(seq_err), 128'(m_seq));
      chk("overflow", 128'(overflow), 128'(m_ovf));
      chk("blk_count", 128'(blk_count), 128'(m_cnt));
      if (sb_q.size() != 0 && bus.blk_ready) begin
        void'(sb_q.pop_front());
        pop_pending = 1;
      end
    end
  end

  task automatic drv(bit v, int n, logic [7:0] d);
    bus.in_valid    = v;
    bus.in_byte_num = n[3:0];
    bus.in_data     = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    clear_err    = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) drv(0, 0, 8'h00);
  endtask

  task automatic send_block(logic [7:0] base, bit inc);
    for (int i = 0; i < 16; i++) drv(1, i, inc ? base + 8'(i) : base);
  endtask

  task automatic clr();
    clear_err = 1'b1;
    idle(1);
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_valid"}, 128'(bus.blk_valid), 128'd0);
    chk({tag, "_data"}, bus.blk_data, 128'd0);
    chk({tag, "_count"}, 128'(blk_count), 128'd0);
    chk({tag, "_seq"}, 128'(seq_err), 128'd0);
    chk({tag, "_ovf"}, 128'(overflow), 128'd0);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.in_byte_num = '0; bus.in_data = '0; bus.blk_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst0");
    rst = 1'b1;
    started = 1;

    // 1: back-to-back block, one-cycle latency
    for (int i = 0; i < 16; i++) drv(1, i, 8'(i));
    chk("t1_valid", 128'(bus.blk_valid), 128'd1);
    chk("t1_data", bus.blk_data, 128'h000102030405060708090a0b0c0d0e0f);
    idle(2);
    chk("t1_count", 128'(blk_count), 128'd1);

    // 2: gap mid-block
    for (int i = 0; i < 16; i++) begin
      drv(1, i, 8'(i));
      if (i == 7) idle(3);
    end
    idle(2);
    chk("t2_seq", 128'(seq_err), 128'd0);
    chk("t2_count", 128'(blk_count), 128'd2);

    // 3: order violation then recovery
    for (int i = 0; i < 6; i++) drv(1, i, 8'(i));
    drv(1, 9, 8'h09);
    chk("t3_seq", 128'(seq_err), 128'd1);
    send_block(8'hAA, 0);
    idle(2);
    chk("t3_count", 128'(blk_count), 128'd3);
    clr();
    chk("t3_clr", 128'(seq_err), 128'd0);

    // 4: FIFO fills, third block dropped
    bus.blk_ready = 1'b0;
    send_block(8'h10, 1);
    send_block(8'h20, 1);
    send_block(8'h30, 1);
    idle(1);
    chk("t4_ovf", 128'(overflow), 128'd1);
    chk("t4_head", bus.blk_data, mk_blk(8'h10, 1));
    chk("t4_count", 128'(blk_count), 128'd3);
    clr();
    chk("t4_clr", 128'(overflow), 128'd0);

    // 5: push into full FIFO with same-cycle pop
    for (int i = 0; i < 15; i++) drv(1, i, 8'h40 + 8'(i));
    bus.blk_ready = 1'b1;
    drv(1, 15, 8'h4F);
    chk("t5_ovf", 128'(overflow), 128'd0);
    idle(4);
    chk("t5_count", 128'(blk_count), 128'd6);

    // 6: reset mid-block
    for (int i = 0; i < 9; i++) drv(1, i, 8'h60 + 8'(i));
    rst = 1'b0;
    idle(1);
    chk_reset_state("t6");
    rst = 1'b1;
    send_block(8'h50, 1);
    idle(2);
    chk("t6_seq", 128'(seq_err), 128'd0);
    chk("t6_count", 128'(blk_count), 128'd1);

    // Random: mostly ordered streams with corruptions, gaps, backpressure and clears
    repeat (60) begin
      for (int i = 0; i < 16; i++) begin
        n = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 15)) : i;
        bus.blk_ready = ($urandom_range(0, 2) != 0);
        clear_err = ($urandom_range(0, 15) == 0);
        drv(1, n, 8'($urandom));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end

    bus.blk_ready = 1'b1;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) idle(1);
    chk("drain", 128'(sb_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
